// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSVD = 3'b111
    } usr_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } usr_state_t;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step unit: computes the next register value and the bit
// moved out for one shift/rotate step of the selected opcode.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_op_t          op,
    input  logic [WIDTH-1:0] d,
    input  logic             i_sl,
    input  logic             i_sr,
    output logic [WIDTH-1:0] d_next,
    output logic             sout
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        d_next = d;
        sout   = 1'b0;
        case (op)
            OP_SHL: begin
                d_next = {d[WIDTH-2:0], i_sr};
                sout   = d[WIDTH-1];
            end
            OP_SHR: begin
                d_next = {i_sl, d[WIDTH-1:1]};
                sout   = d[0];
            end
            OP_ROL: begin
                d_next = {d[WIDTH-2:0], d[WIDTH-1]};
                sout   = d[WIDTH-1];
            end
            OP_ROR: begin
                d_next = {d[0], d[WIDTH-1:1]};
                sout   = d[0];
            end
            OP_ASR: begin
                d_next = {d[WIDTH-1], d[WIDTH-1:1]};
                sout   = d[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Universal shift register with valid/ready command handshake; shift commands
// run one single-bit step per clock for a saturated step count.
module universal_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sl,
    input  logic             i_sr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sout,
    output logic             o_done,
    output logic             o_err
);

    usr_state_t       state_q, state_d;
    usr_op_t          op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [AMT_W-1:0] amt_sat;
    logic [WIDTH-1:0] step_data;
    logic             step_sout;
    usr_op_t          op_in;

    assign op_in   = usr_op_t'(i_op);
    assign amt_sat = (i_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : i_amt;

    // The step unit always works on the latched opcode, so i_op may change freely during RUN.
    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .d      (data_q),
        .i_sl   (i_sl),
        .i_sr   (i_sr),
        .d_next (step_data),
        .sout   (step_sout)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    op_d = op_in;
                    case (op_in)
                        OP_HOLD: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        OP_LOAD: begin
                            data_d  = i_data;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        OP_RSVD: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                        default: begin
                            if (amt_sat == '0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                cnt_d   = amt_sat;
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                data_d = step_data;
                sout_d = step_sout;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_data  = data_q;
    assign o_sout  = sout_q;
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Self-checking bench for universal_shift_reg_n (WIDTH=8): directed scenarios
// followed by random commands checked against an arithmetic reference model.
module tb_universal_shift_reg_n;

    localparam int W     = 8;
    localparam int AW    = $clog2(W) + 1;
    localparam int MASK  = (1 << W) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [2:0]    i_op = 3'd0;
    logic [AW-1:0] i_amt = '0;
    logic [W-1:0]  i_data = '0;
    logic          i_sl = 1'b0;
    logic          i_sr = 1'b0;
    logic [W-1:0]  o_data;
    logic          o_sout;
    logic          o_done;
    logic          o_err;

    int n_tests = 0;
    int n_fail  = 0;

    int model_data = 0;
    int model_sout = 0;

    universal_shift_reg_n #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_amt   (i_amt),
        .i_data  (i_data),
        .i_sl    (i_sl),
        .i_sr    (i_sr),
        .o_data  (o_data),
        .o_sout  (o_sout),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the command's effect as k arithmetic single-bit steps.
    task automatic model_cmd(input int op, input int amt, input int data, input int sl, input int sr);
        int k;
        k = (amt > W) ? W : amt;
        if (op == 1) model_data = data & MASK;
        if (op >= 2 && op <= 6) begin
            for (int s = 0; s < k; s++) begin
                case (op)
                    2: begin model_sout = (model_data >> (W-1)) & 1; model_data = ((model_data << 1) | sr) & MASK; end
                    3: begin model_sout = model_data & 1; model_data = (model_data >> 1) | (sl << (W-1)); end
                    4: begin model_sout = (model_data >> (W-1)) & 1; model_data = ((model_data << 1) | model_sout) & MASK; end
                    5: begin model_sout = model_data & 1; model_data = (model_data >> 1) | (model_sout << (W-1)); end
                    default: begin model_sout = model_data & 1; model_data = (model_data >> 1) | (model_data & (1 << (W-1))); end
                endcase
            end
        end
    endtask

    function automatic int steps_of(input int op, input int amt);
        if (op < 2 || op > 6) return 0;
        return (amt > W) ? W : amt;
    endfunction

    // Starts and ends at a falling edge with the DUT idle.
    task automatic run_cmd(input string tag, input int op, input int amt, input int data,
                           input int sl, input int sr);
        int k, cyc;
        check({tag, "/ready_before"}, o_ready, 1);
        i_valid = 1'b1;
        i_op    = op[2:0];
        i_amt   = amt[AW-1:0];
        i_data  = data[W-1:0];
        i_sl    = sl[0];
        i_sr    = sr[0];
        @(negedge i_clk);
        i_valid = 1'b0;
        i_op    = 3'($urandom);
        i_amt   = AW'($urandom);
        i_data  = W'($urandom);
        model_cmd(op, amt, data, sl, sr);
        k   = steps_of(op, amt);
        cyc = 0;
        while (!o_done && cyc < 20) begin
            check({tag, "/busy"}, o_ready, 0);
            @(negedge i_clk);
            cyc++;
        end
        check({tag, "/latency"}, cyc, k);
        check({tag, "/data"}, o_data, model_data);
        check({tag, "/sout"}, o_sout, model_sout);
        check({tag, "/err"}, o_err, (op == 7) ? 1 : 0);
        check({tag, "/ready_in_done"}, o_ready, 0);
        @(negedge i_clk);
        check({tag, "/done_one_cycle"}, o_done, 0);
        check({tag, "/err_one_cycle"}, o_err, 0);
        check({tag, "/ready_after"}, o_ready, 1);
        check({tag, "/data_holds"}, o_data, model_data);
    endtask

    initial begin
        int op, amt, data, sl, sr, cyc;

        // Power-on reset state.
        #12;
        check("reset/data", o_data, 0);
        check("reset/ready", o_ready, 1);
        check("reset/done", o_done, 0);
        check("reset/err", o_err, 0);
        check("reset/sout", o_sout, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Reset mid-RUN: SHL amt=5, reset asserted two cycles after accept.
        run_cmd("pre_load", 1, 0, 8'h3C, 0, 0);
        i_valid = 1'b1; i_op = 3'b010; i_amt = AW'(5); i_sr = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("midrun/ready_low", o_ready, 0);
        i_rst_n = 1'b0;
        #1;
        check("midrun_rst/data", o_data, 0);
        check("midrun_rst/ready", o_ready, 1);
        check("midrun_rst/done", o_done, 0);
        check("midrun_rst/sout", o_sout, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        check("midrun_rst/no_done", o_done, 0);
        i_rst_n = 1'b1;
        model_data = 0;
        model_sout = 0;
        @(negedge i_clk);
        check("after_rst/no_done", o_done, 0);

        // Directed command sequence.
        run_cmd("load_a5", 1, 0, 8'hA5, 0, 0);
        check("load_a5/value", o_data, 8'hA5);
        run_cmd("shl3", 2, 3, 0, 0, 1);
        check("shl3/value", o_data, 8'h2F);
        check("shl3/sout_value", o_sout, 1);
        run_cmd("shr2", 3, 2, 0, 0, 0);
        check("shr2/value", o_data, 8'h0B);
        check("shr2/sout_value", o_sout, 1);
        run_cmd("load_81", 1, 0, 8'h81, 0, 0);
        run_cmd("rol1", 4, 1, 0, 0, 0);
        check("rol1/value", o_data, 8'h03);
        run_cmd("ror8", 5, 8, 0, 0, 0);
        check("ror8/value", o_data, 8'h03);
        run_cmd("load_90", 1, 0, 8'h90, 0, 0);
        run_cmd("asr3", 6, 3, 0, 0, 0);
        check("asr3/value", o_data, 8'hF2);
        run_cmd("shl_amt0", 2, 0, 0, 1, 1);
        check("shl_amt0/value", o_data, 8'hF2);
        run_cmd("shr_amt15", 3, 15, 0, 0, 0);
        check("shr_amt15/value", o_data, 8'h00);
        run_cmd("load_5a", 1, 0, 8'h5A, 0, 0);
        run_cmd("rsvd", 7, 3, 8'hFF, 1, 1);
        check("rsvd/value", o_data, 8'h5A);
        run_cmd("hold", 0, 4, 8'hFF, 1, 1);
        check("hold/value", o_data, 8'h5A);

        // i_valid held high through RUN: only the next IDLE accepts the LOAD.
        i_valid = 1'b1; i_op = 3'b010; i_amt = AW'(3); i_sr = 1'b0;
        @(negedge i_clk);
        model_cmd(2, 3, 0, 0, 0);
        i_op = 3'b001; i_data = 8'hFF;
        cyc = 0;
        while (!o_done && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        check("held_valid/latency", cyc, 3);
        check("held_valid/shift_result", o_data, model_data);
        @(negedge i_clk);
        check("held_valid/ready", o_ready, 1);
        check("held_valid/not_loaded_yet", o_data, model_data);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("held_valid/load_done", o_done, 1);
        check("held_valid/load_value", o_data, 8'hFF);
        model_data = 8'hFF;
        @(negedge i_clk);

        // Random commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            op   = int'($urandom_range(0, 7));
            amt  = int'($urandom_range(0, 15));
            data = int'($urandom_range(0, 255));
            sl   = int'($urandom_range(0, 1));
            sr   = int'($urandom_range(0, 1));
            run_cmd($sformatf("rand%0d_op%0d_amt%0d", n, op, amt), op, amt, data, sl, sr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
